// File: rtl/pio_cmd_pkg.sv
// Shared opcodes, status bit positions, box record and FSM encoding for pio_cmd_receiver.
package pio_cmd_pkg;

  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_BOX_LO  = 4'd1;
  localparam logic [3:0] OP_BOX_HI  = 4'd2;
  localparam logic [3:0] OP_CLEAR   = 4'd3;
  localparam logic [3:0] OP_SET_HEX = 4'd4;

  localparam int ST_ACK     = 15;
  localparam int ST_OVF     = 14;
  localparam int ST_ERR_SEQ = 13;
  localparam int ST_ERR_OP  = 12;
  localparam int ST_FSM_LSB = 8;
  localparam int ST_CNT_LSB = 0;

  // Box fields are sized for the widest supported coordinate; narrower builds zero-extend.
  localparam int COORD_MAX = 16;

  typedef struct packed {
    logic [COORD_MAX-1:0] x0;
    logic [COORD_MAX-1:0] y0;
    logic [COORD_MAX-1:0] x1;
    logic [COORD_MAX-1:0] y1;
  } box_t;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    HAVE_LO = 4'd1
  } fsm_t;

endpackage

// File: rtl/box_fifo.sv
// Registered FIFO with push/pop/flush; a push into a full FIFO succeeds only alongside a pop.
module box_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 40,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush && !reset) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pio_cmd_receiver.sv
// Decodes toggle-strobed HPS PIO commands into boxes, hex value and status.
// Define BOX_CLIP_EN to order and clamp box corners to the frame before they are queued.
module pio_cmd_receiver
  import pio_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int COORD_W    = 10,
  parameter int FRAME_W    = 640,
  parameter int FRAME_H    = 480
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          pio_data,
  input  logic [15:0]          pio_ctrl,
  output logic                 box_valid,
  input  logic                 box_ready,
  output logic [4*COORD_W-1:0] box_data,
  output logic [15:0]          hex_value,
  output logic [15:0]          status
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [31:0]        d_q;
  logic [15:0]        c_q;
  logic               s_prev, armed, ack_toggle, overflow, err_seq, err_op;
  fsm_t               state;
  logic [COORD_W-1:0] lo_x, lo_y;
  logic [COORD_W-1:0] xa, xb, ya, yb;
  box_t               nb;
  logic               strobe_edge, push, pop, flush, full, empty;
  logic [3:0]         op;
  logic [AW:0]        fifo_cnt;
  logic [31:0]        cnt_ext;
  logic [7:0]         cnt8;
  logic [4*COORD_W-1:0] rdata;
  logic               unused_bits;

  // Inputs are sampled even during reset so arming sees the held strobe level.
  always_ff @(posedge clk) begin
    d_q <= pio_data;
    c_q <= pio_ctrl;
  end

  assign op          = c_q[3:0];
  assign strobe_edge = armed & (c_q[15] ^ s_prev);
  assign pop         = box_valid & box_ready;
  assign push        = strobe_edge & (op == OP_BOX_HI) & (state == HAVE_LO);
  assign flush       = strobe_edge & (op == OP_CLEAR);

  always_comb begin
    xa = lo_x;
    ya = lo_y;
    xb = d_q[16 +: COORD_W];
    yb = d_q[0  +: COORD_W];
`ifdef BOX_CLIP_EN
    if (xa > xb) begin xa = xb; xb = lo_x; end
    if (ya > yb) begin ya = yb; yb = lo_y; end
    if (32'(xa) > 32'(FRAME_W - 1)) xa = COORD_W'(FRAME_W - 1);
    if (32'(xb) > 32'(FRAME_W - 1)) xb = COORD_W'(FRAME_W - 1);
    if (32'(ya) > 32'(FRAME_H - 1)) ya = COORD_W'(FRAME_H - 1);
    if (32'(yb) > 32'(FRAME_H - 1)) yb = COORD_W'(FRAME_H - 1);
`endif
    nb    = '0;
    nb.x0 = COORD_MAX'(xa);
    nb.y0 = COORD_MAX'(ya);
    nb.x1 = COORD_MAX'(xb);
    nb.y1 = COORD_MAX'(yb);
  end

  box_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(4*COORD_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({nb.x0[COORD_W-1:0], nb.y0[COORD_W-1:0], nb.x1[COORD_W-1:0], nb.y1[COORD_W-1:0]}),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      armed      <= 1'b0;
      s_prev     <= 1'b0;
      ack_toggle <= 1'b0;
      overflow   <= 1'b0;
      err_seq    <= 1'b0;
      err_op     <= 1'b0;
      state      <= IDLE;
      lo_x       <= '0;
      lo_y       <= '0;
      hex_value  <= '0;
    end else if (!armed) begin
      armed  <= 1'b1;
      s_prev <= c_q[15];
    end else if (strobe_edge) begin
      s_prev     <= c_q[15];
      ack_toggle <= c_q[15];
      case (op)
        OP_NOP: ;
        OP_BOX_LO: begin
          lo_x  <= d_q[16 +: COORD_W];
          lo_y  <= d_q[0  +: COORD_W];
          state <= HAVE_LO;
        end
        OP_BOX_HI: begin
          if (state == HAVE_LO) begin
            state <= IDLE;
            if (full && !pop) overflow <= 1'b1;
          end else begin
            err_seq <= 1'b1;
          end
        end
        OP_CLEAR: begin
          overflow <= 1'b0;
          err_seq  <= 1'b0;
          err_op   <= 1'b0;
          state    <= IDLE;
        end
        OP_SET_HEX: hex_value <= d_q[15:0];
        default:    err_op    <= 1'b1;
      endcase
    end
  end

  assign box_valid = ~empty;
  assign box_data  = empty ? '0 : rdata;
  assign cnt_ext   = 32'(fifo_cnt);
  assign cnt8      = (cnt_ext > 32'd255) ? 8'hFF : cnt_ext[7:0];

  always_comb begin
    status                         = '0;
    status[ST_ACK]                 = ack_toggle;
    status[ST_OVF]                 = overflow;
    status[ST_ERR_SEQ]             = err_seq;
    status[ST_ERR_OP]              = err_op;
    status[ST_FSM_LSB +: 4]        = state;
    status[ST_CNT_LSB +: 8]        = cnt8;
  end

  assign unused_bits = ^{c_q[14:4], d_q, nb};

endmodule

// File: doc/pio_cmd_receiver.md
Name: pio_cmd_receiver

Overview:
- Consumes the two HPS-written PIO buses (32-bit data on PIO 0, 16-bit control on PIO 1).
- Decodes toggle-strobed commands from the ARM detection software into bounding-box records, hex display values and status.
- Buffers boxes in a small FIFO and streams them to the downstream VGA overlay stage using a valid/ready handshake.
- Returns a status word for an HPS-readable input PIO.

Parameters:
- FIFO_DEPTH, 8, box FIFO entries; power of two, at least 2.
- COORD_W, 10, output coordinate width in bits.
- FRAME_W, 640, frame width in pixels; used only with clipping.
- FRAME_H, 480, frame height in pixels; used only with clipping.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- pio_data  in  32  PIO 0 word: [31:16]=x or hex payload, [15:0]=y.
- pio_ctrl  in  16  PIO 1 word: [15]=strobe toggle, [11:4]=tag (ignored), [3:0]=opcode.
- box_valid  out  1  box available.
- box_ready  in  1  downstream accepts box.
- box_data  out  4*COORD_W  {x0,y0,x1,y1}.
- hex_value  out  16  to the four HexDigit instances.
- status  out  16  [15]=ack_toggle, [14]=overflow, [13]=err_seq, [12]=err_op, [11:8]=fsm_state, [7:0]=fifo_count.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. While reset is high, all outputs are 0, the FIFO is empty and the FSM is IDLE.
- Input stage: pio_data and pio_ctrl are registered to d_q and c_q every cycle. s_prev holds the last accepted strobe.
- Arming: a flag `armed` clears on reset. The first cycle after reset with armed=0 loads s_prev <= c_q[15], sets armed, and executes nothing. A strobe level that is already 1 at reset therefore never triggers a command.
- Edge detection: edge = armed & (c_q[15] ^ s_prev). On an edge, the opcode executes and s_prev <= c_q[15] and ack_toggle <= c_q[15] in the same cycle. ack_toggle therefore appears on status 2 clocks after pio_ctrl changes.
- Opcodes:
  - 0 NOP: ack only.
  - 1 BOX_LO: latch x0=d_q[31:16], y0=d_q[15:0], each truncated to COORD_W. FSM -> HAVE_LO. A BOX_LO in HAVE_LO overwrites the latch.
  - 2 BOX_HI: in HAVE_LO, push {x0,y0,x1,y1} and go to IDLE. In IDLE, set err_seq sticky; no push.
  - 3 CLEAR: flush the FIFO, clear overflow/err_seq/err_op, FSM -> IDLE. hex_value is unchanged.
  - 4 SET_HEX: hex_value <= d_q[15:0].
  - 5-15: set err_op sticky; no other effect.
- FSM: IDLE(0) and HAVE_LO(1). Only the transitions above exist.
- FIFO: registered. box_valid rises the cycle after a push into an empty FIFO.
  - Pop occurs when box_valid & box_ready.
  - Push while full with a pop in the same cycle: both happen; count is unchanged.
  - Push while full without a pop: box dropped, overflow sticky set.
  - CLEAR in the same cycle as a pop: CLEAR wins; box_valid is 0 next cycle.
  - Pointers wrap modulo FIFO_DEPTH. fifo_count saturates its 8-bit field only when FIFO_DEPTH > 255.
- box_data is stable while box_valid & !box_ready.
- Reset mid-stream discards all state. Re-arming follows the next clock.

Optional Feature:
- BOX_CLIP_EN defined: at BOX_HI, coordinates are processed before the push:
  - x0/x1 and y0/y1 are swapped if reversed.
  - x is clamped to FRAME_W-1 and y to FRAME_H-1.
  - This adds no latency.
- BOX_CLIP_EN undefined: coordinates pass through truncated, unchanged.

Decomposition:
- Package pio_cmd_pkg holds:
  - opcode localparams OP_NOP..OP_SET_HEX;
  - status bit index constants;
  - the box_t struct {x0,y0,x1,y1};
  - the fsm_t enum.
- One sub-module: box_fifo (parameterised depth/width, push/pop/flush/full/empty/count).

Test Plan:
- Reset with pio_ctrl[15]=1 held -> no command executes, status=0x0000. Toggling [15] to 0 with opcode 4, data 0x0000BEEF -> hex_value=0xBEEF, status[15]=0 two clocks later.
- BOX_LO data 0x0064_0032, then BOX_HI data 0x00C8_0096, box_ready=1 -> one beat box_data={100,50,200,150}, fifo_count returns to 0.
- BOX_HI from IDLE -> status[13]=1, no box_valid. Then opcode 3 -> status[13]=0.
- box_ready=0, nine box pairs with FIFO_DEPTH=8 -> fifo_count=8, status[14]=1. Boxes 1-8 drain in order; the ninth is absent.
- Opcode 9 -> status[12]=1 and ack toggles. CLEAR asserted together with a pop -> box_valid=0 the following cycle.
- With BOX_CLIP_EN: BOX_LO (700,10), BOX_HI (5,900) -> box_data={5,10,639,479}.
